// File: rtl/tri_traversal.sv
// Triangle bounding-box traversal: enumerates every candidate pixel of a triangle's
// screen-clipped bounding box in row-major order. Optional stats: TRI_TRAVERSAL_STATS_EN.
package tri_traversal_pkg;

    typedef struct packed {
        logic [31:0] x;      // Q16.16 signed
        logic [31:0] y;      // Q16.16 signed
        logic [23:0] color;
        logic [31:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t     v0;
        vertex_t     v1;
        vertex_t     v2;
        logic [15:0] x;
        logic [15:0] y;
    } pixel_state_t;

endpackage

module tri_traversal
    import tri_traversal_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic         clk,
    input  logic         rst_n,
    input  pixel_state_t in_tri,
    input  logic         in_valid,
    output logic         in_ready,
    output pixel_state_t out_pixel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         tri_done,
    output logic         busy
`ifdef TRI_TRAVERSAL_STATS_EN
    ,
    output logic [31:0]  pix_count,
    output logic [31:0]  tri_count
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

    localparam logic signed [16:0] x_lim = 17'(WIDTH - 1);
    localparam logic signed [16:0] y_lim = 17'(HEIGHT - 1);

    state_t      state;
    logic [15:0] xmin;
    logic [15:0] xmax;
    logic [15:0] ymax;

    logic signed [16:0] bx_min, bx_max, by_min, by_max;
    logic signed [16:0] cx_min, cx_max, cy_min, cy_max;
    logic               empty_box;

    // 17 bits keep the ceiling's +1 from overflowing at the top of the Q16.16 range.
    function automatic logic signed [16:0] floor_q(input logic [31:0] q);
        return $signed({q[31], q[31:16]});
    endfunction

    function automatic logic signed [16:0] ceil_q(input logic [31:0] q);
        return floor_q(q) + $signed({16'd0, |q[15:0]});
    endfunction

    function automatic logic signed [16:0] min3(input logic signed [16:0] a, b, c);
        logic signed [16:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [16:0] max3(input logic signed [16:0] a, b, c);
        logic signed [16:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The latched triangle lives in out_pixel, so the box is derived from it during SETUP.
    always_comb begin
        bx_min    = min3(floor_q(out_pixel.v0.x), floor_q(out_pixel.v1.x), floor_q(out_pixel.v2.x));
        bx_max    = max3(ceil_q(out_pixel.v0.x), ceil_q(out_pixel.v1.x), ceil_q(out_pixel.v2.x));
        by_min    = min3(floor_q(out_pixel.v0.y), floor_q(out_pixel.v1.y), floor_q(out_pixel.v2.y));
        by_max    = max3(ceil_q(out_pixel.v0.y), ceil_q(out_pixel.v1.y), ceil_q(out_pixel.v2.y));
        cx_min    = (bx_min < 0) ? '0 : bx_min;
        cx_max    = (bx_max > x_lim) ? x_lim : bx_max;
        cy_min    = (by_min < 0) ? '0 : by_min;
        cy_max    = (by_max > y_lim) ? y_lim : by_max;
        empty_box = (cx_min > cx_max) || (cy_min > cy_max);
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // NOTE: every register here uses non-blocking assignment so all of them update
    // from the same pre-edge values; there is no RAM, so everything gets a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_pixel <= '0;
            tri_done  <= 1'b0;
            xmin      <= '0;
            xmax      <= '0;
            ymax      <= '0;
        end else begin
            tri_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_pixel <= in_tri;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (empty_box) begin
                        state    <= IDLE;
                        tri_done <= 1'b1;
                    end else begin
                        xmin        <= cx_min[15:0];
                        xmax        <= cx_max[15:0];
                        ymax        <= cy_max[15:0];
                        out_pixel.x <= cx_min[15:0];
                        out_pixel.y <= cy_min[15:0];
                        out_valid   <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        if (out_pixel.x != xmax) begin
                            out_pixel.x <= out_pixel.x + 16'd1;
                        end else if (out_pixel.y != ymax) begin
                            out_pixel.x <= xmin;
                            out_pixel.y <= out_pixel.y + 16'd1;
                        end else begin
                            out_valid <= 1'b0;
                            tri_done  <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRI_TRAVERSAL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_count <= '0;
            tri_count <= '0;
        end else begin
            if (out_valid && out_ready) pix_count <= pix_count + 32'd1;
            if (tri_done)               tri_count <= tri_count + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tri_traversal.sv
// Self-checking bench for tri_traversal: randomized backpressure and triangles scored
// against a bounding-box model built from plain integer arithmetic.
module tb_tri_traversal;
    import tri_traversal_pkg::*;

    localparam int W = 320;
    localparam int H = 240;

    logic         clk = 1'b0;
    logic         rst_n;
    pixel_state_t in_tri;
    logic         in_valid;
    logic         in_ready;
    pixel_state_t out_pixel;
    logic         out_valid;
    logic         out_ready;
    logic         tri_done;
    logic         busy;
`ifdef TRI_TRAVERSAL_STATS_EN
    logic [31:0]  pix_count;
    logic [31:0]  tri_count;
`endif

    always #5 clk = ~clk;

    tri_traversal #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_tri(in_tri),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_pixel(out_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .tri_done(tri_done),
        .busy(busy)
`ifdef TRI_TRAVERSAL_STATS_EN
        ,
        .pix_count(pix_count),
        .tri_count(tri_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Expected pixel list from the model, observed list from the DUT.
    int exp_x[$];
    int exp_y[$];
    int got_x[$];
    int got_y[$];
    int exp_pix = 0;
    int exp_tri = 0;

    // Per-run observations.
    int first_lat, done_lat, done_cnt, stall_err, ready_err, payload_err;
    int wait_cyc, extra_err, valid_cycles;
    bit timeout;

    function automatic int fx(input int ip, input int frac);
        return ip * 65536 + frac;
    endfunction

    function automatic pixel_state_t make_tri(input int x0, y0, x1, y1, x2, y2);
        pixel_state_t t;
        t          = '0;
        t.v0.x     = x0;  t.v0.y = y0;
        t.v1.x     = x1;  t.v1.y = y1;
        t.v2.x     = x2;  t.v2.y = y2;
        t.v0.color = 24'($urandom);  t.v0.z = $urandom;
        t.v1.color = 24'($urandom);  t.v1.z = $urandom;
        t.v2.color = 24'($urandom);  t.v2.z = $urandom;
        t.x        = 16'($urandom);  // must be ignored by the DUT
        t.y        = 16'($urandom);
        return t;
    endfunction

    // Bounding box from floor/ceil of the real-valued coordinates, clipped to the screen.
    task automatic build_model(input pixel_state_t t);
        int xs[3];
        int ys[3];
        int xlo, xhi, ylo, yhi;
        xs = '{int'(t.v0.x), int'(t.v1.x), int'(t.v2.x)};
        ys = '{int'(t.v0.y), int'(t.v1.y), int'(t.v2.y)};
        xlo = 1 << 30;  xhi = -(1 << 30);
        ylo = 1 << 30;  yhi = -(1 << 30);
        for (int i = 0; i < 3; i++) begin
            int fx_i, cx_i, fy_i, cy_i;
            fx_i = xs[i] >>> 16;
            cx_i = fx_i + (((xs[i] & 32'hFFFF) != 0) ? 1 : 0);
            fy_i = ys[i] >>> 16;
            cy_i = fy_i + (((ys[i] & 32'hFFFF) != 0) ? 1 : 0);
            if (fx_i < xlo) xlo = fx_i;
            if (cx_i > xhi) xhi = cx_i;
            if (fy_i < ylo) ylo = fy_i;
            if (cy_i > yhi) yhi = cy_i;
        end
        if (xlo < 0) xlo = 0;
        if (ylo < 0) ylo = 0;
        if (xhi > W - 1) xhi = W - 1;
        if (yhi > H - 1) yhi = H - 1;
        exp_x.delete();
        exp_y.delete();
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endtask

    function automatic int first_mismatch();
        int n;
        n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        for (int i = 0; i < n; i++)
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) return i;
        return -1;
    endfunction

    // Presents one triangle and records what comes out. Must be entered at a negedge.
    // has_next keeps in_valid high with nxt for a back-to-back follow-on triangle.
    task automatic run_tri(input pixel_state_t t, input int pct, input bit has_next,
                           input pixel_state_t nxt, input int abort_after, input int tail);
        bit           prev_stall;
        pixel_state_t prev_pix;
        bit           r;
        int           budget;
        build_model(t);
        got_x.delete();  got_y.delete();
        first_lat = -1;  done_lat = -1;  done_cnt = 0;  stall_err = 0;  ready_err = 0;
        payload_err = 0; extra_err = 0;  valid_cycles = 0;  timeout = 0;  wait_cyc = 0;
        prev_stall = 0;  prev_pix = '0;
        in_tri   = t;
        in_valid = 1'b1;
        while (!in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!in_ready) begin
            timeout  = 1;
            in_valid = 1'b0;
            return;
        end
        budget = 4 * exp_x.size() + 40;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (has_next) in_tri = nxt;
                else          in_valid = 1'b0;
            end
            if (prev_stall && (!out_valid || out_pixel !== prev_pix)) stall_err++;
            if (tri_done !== in_ready) ready_err++;
            if (out_valid) valid_cycles++;
            if (out_valid && first_lat < 0) first_lat = cyc;
            if (tri_done) begin
                done_cnt++;
                done_lat = cyc;
                break;
            end
            r         = ($urandom_range(99, 0) < pct);
            out_ready = r;
            if (out_valid && r) begin
                got_x.push_back(int'(out_pixel.x));
                got_y.push_back(int'(out_pixel.y));
                if (out_pixel.v0 !== t.v0 || out_pixel.v1 !== t.v1 || out_pixel.v2 !== t.v2)
                    payload_err++;
            end
            prev_stall = out_valid && !r;
            prev_pix   = out_pixel;
            if (abort_after > 0 && got_x.size() == abort_after) return;
        end
        if (done_lat < 0) timeout = 1;
        for (int i = 0; i < tail; i++) begin
            @(negedge clk);
            if (tri_done || out_valid) extra_err++;
            out_ready = ($urandom_range(99, 0) < pct);
        end
        exp_pix += exp_x.size();
        exp_tri += 1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_tri    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (tri_done !== 1'b0)  begin errors++; $display("FAIL reset_tri_done: got %b want 0", tri_done); end
        checks++; if (out_pixel !== '0)   begin errors++; $display("FAIL reset_out_pixel: got %h want 0", out_pixel); end
`ifdef TRI_TRAVERSAL_STATS_EN
        checks++; if (pix_count !== 32'd0 || tri_count !== 32'd0) begin
            errors++; $display("FAIL reset_stats: got pix=%0d tri=%0d want 0 0", pix_count, tri_count);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pixel_state_t t;
        int m;
        t = make_tri(fx(2, 0), fx(3, 0), fx(5, 32768), fx(3, 0), fx(2, 0), fx(4, 16384));
        run_tri(t, 100, 1'b0, '0, 0, 3);
        m = first_mismatch();
        checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: got timeout want tri_done"); end
        checks++; if (got_x.size() != 15) begin errors++; $display("FAIL basic_count: got %0d want 15", got_x.size()); end
        checks++; if (m != -1) begin errors++; $display("FAIL basic_order: pixel %0d got (%0d,%0d) want (%0d,%0d)", m, got_x[m], got_y[m], exp_x[m], exp_y[m]); end
        checks++; if (got_x.size() > 0 && (got_x[0] != 2 || got_y[0] != 3)) begin errors++; $display("FAIL basic_first: got (%0d,%0d) want (2,3)", got_x[0], got_y[0]); end
        checks++; if (got_x.size() > 0 && (got_x[$] != 6 || got_y[$] != 5)) begin errors++; $display("FAIL basic_last: got (%0d,%0d) want (6,5)", got_x[$], got_y[$]); end
        checks++; if (first_lat != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", first_lat); end
        checks++; if (done_lat != 17) begin errors++; $display("FAIL basic_throughput: tri_done at %0d want 17", done_lat); end
        checks++; if (done_cnt != 1 || extra_err != 0) begin errors++; $display("FAIL basic_done_pulse: got %0d extra=%0d want 1 0", done_cnt, extra_err); end
        checks++; if (payload_err != 0) begin errors++; $display("FAIL basic_payload: got %0d bad want 0", payload_err); end
        checks++; if (ready_err != 0) begin errors++; $display("FAIL basic_in_ready: got %0d bad cycles want 0", ready_err); end
    endtask

    task automatic test_clip();
        pixel_state_t t;
        int m, bad;
        t = make_tri(fx(-4, 0), fx(10, 0), fx(400, 0), fx(10, 0), fx(-4, 0), fx(10, 0));
        run_tri(t, 100, 1'b0, '0, 0, 2);
        m   = first_mismatch();
        bad = 0;
        foreach (got_x[i]) if (got_x[i] >= W || got_x[i] < 0 || got_y[i] != 10) bad++;
        checks++; if (timeout) begin errors++; $display("FAIL clip_timeout: got timeout want tri_done"); end
        checks++; if (got_x.size() != 320) begin errors++; $display("FAIL clip_count: got %0d want 320", got_x.size()); end
        checks++; if (m != -1) begin errors++; $display("FAIL clip_order: pixel %0d got (%0d,%0d) want (%0d,%0d)", m, got_x[m], got_y[m], exp_x[m], exp_y[m]); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clip_range: got %0d off-screen pixels want 0", bad); end
    endtask

    task automatic test_reject();
        pixel_state_t t;
        t = make_tri(fx(-10, 0), fx(5, 0), fx(-3, 0), fx(5, 0), fx(-5, 32768), fx(8, 0));
        run_tri(t, 100, 1'b0, '0, 0, 3);
        checks++; if (valid_cycles != 0 || extra_err != 0) begin errors++; $display("FAIL reject_valid: got %0d valid cycles extra=%0d want 0", valid_cycles, extra_err); end
        checks++; if (done_lat != 2) begin errors++; $display("FAIL reject_done_lat: got %0d want 2", done_lat); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reject_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_backpressure();
        pixel_state_t t;
        int m;
        t = make_tri(fx(2, 0), fx(3, 0), fx(5, 32768), fx(3, 0), fx(2, 0), fx(4, 16384));
        run_tri(t, 45, 1'b0, '0, 0, 2);
        m = first_mismatch();
        checks++; if (timeout) begin errors++; $display("FAIL bp_timeout: got timeout want tri_done"); end
        checks++; if (got_x.size() != 15) begin errors++; $display("FAIL bp_count: got %0d want 15", got_x.size()); end
        checks++; if (m != -1) begin errors++; $display("FAIL bp_order: pixel %0d got (%0d,%0d) want (%0d,%0d)", m, got_x[m], got_y[m], exp_x[m], exp_y[m]); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
    endtask

    task automatic test_reset_mid();
        pixel_state_t t;
        int m, dones;
        t = make_tri(fx(20, 0), fx(30, 0), fx(27, 1), fx(30, 0), fx(20, 0), fx(33, 0));
        run_tri(t, 100, 1'b0, '0, 4, 0);
        checks++; if (got_x.size() != 4) begin errors++; $display("FAIL rstmid_pre: got %0d pixels want 4", got_x.size()); end
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_abort: got valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
        end
        exp_pix = 0;
        exp_tri = 0;
        dones   = 0;
        repeat (3) begin
            @(negedge clk);
            if (tri_done) dones++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (tri_done) dones++;
        checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
        t = make_tri(fx(7, 100), fx(1, 0), fx(9, 0), fx(2, 5), fx(8, 0), fx(0, 65535));
        run_tri(t, 70, 1'b0, '0, 0, 1);
        m = first_mismatch();
        checks++; if (got_x.size() != exp_x.size() || timeout) begin errors++; $display("FAIL rstmid_next_count: got %0d want %0d", got_x.size(), exp_x.size()); end
        checks++; if (m != -1) begin errors++; $display("FAIL rstmid_next_order: pixel %0d got (%0d,%0d) want (%0d,%0d)", m, got_x[m], got_y[m], exp_x[m], exp_y[m]); end
    endtask

    task automatic test_back_to_back();
        pixel_state_t t1, t2;
        int m;
        t1 = make_tri(fx(10, 32768), fx(20, 0), fx(13, 0), fx(21, 49152), fx(11, 0), fx(20, 0));
        t2 = make_tri(fx(2, 0), fx(3, 0), fx(5, 32768), fx(3, 0), fx(2, 0), fx(4, 16384));
        run_tri(t1, 100, 1'b1, t2, 0, 0);
        m = first_mismatch();
        checks++; if (got_x.size() != 12 || m != -1) begin errors++; $display("FAIL b2b_first_seq: got %0d pixels mismatch@%0d want 12 -1", got_x.size(), m); end
        checks++; if (ready_err != 0 || done_cnt != 1) begin errors++; $display("FAIL b2b_in_ready: got %0d bad cycles done=%0d want 0 1", ready_err, done_cnt); end
        run_tri(t2, 60, 1'b0, '0, 0, 2);
        m = first_mismatch();
        checks++; if (wait_cyc != 0) begin errors++; $display("FAIL b2b_accept: got wait %0d want 0", wait_cyc); end
        checks++; if (first_lat != 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", first_lat); end
        checks++; if (got_x.size() != 15 || m != -1 || timeout) begin errors++; $display("FAIL b2b_second_seq: got %0d pixels mismatch@%0d want 15 -1", got_x.size(), m); end
`ifdef TRI_TRAVERSAL_STATS_EN
        checks++; if (pix_count !== 32'(exp_pix)) begin errors++; $display("FAIL stats_pix: got %0d want %0d", pix_count, exp_pix); end
        checks++; if (tri_count !== 32'(exp_tri)) begin errors++; $display("FAIL stats_tri: got %0d want %0d", tri_count, exp_tri); end
`endif
    endtask

    task automatic test_random();
        pixel_state_t t;
        int m, base_x, pct;
        int c[6];
        for (int n = 0; n < 5; n++) begin
            base_x = (n == 4) ? 295 : -8;
            foreach (c[i]) c[i] = int'($urandom_range(40 * 65536, 0));
            t = make_tri(c[0] + base_x * 65536, c[1] - 8 * 65536,
                         c[2] + base_x * 65536, c[3] - 8 * 65536,
                         c[4] + base_x * 65536, c[5] - 8 * 65536);
            pct = int'($urandom_range(100, 40));
            run_tri(t, pct, 1'b0, '0, 0, 1);
            m = first_mismatch();
            checks++; if (got_x.size() != exp_x.size() || timeout) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", n, got_x.size(), exp_x.size()); end
            checks++; if (m != -1) begin errors++; $display("FAIL rand%0d_order: pixel %0d got (%0d,%0d) want (%0d,%0d)", n, m, got_x[m], got_y[m], exp_x[m], exp_y[m]); end
            checks++; if (stall_err != 0 || payload_err != 0 || extra_err != 0) begin
                errors++; $display("FAIL rand%0d_protocol: got stall=%0d payload=%0d extra=%0d want 0", n, stall_err, payload_err, extra_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_reject();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
